// File: rtl/matmul_loader.sv
// Front-end loader for the systolic matrix multiplier: accepts (m,n,p), unpacks a
// row-major byte stream into the A and B operand arrays, then runs the multiplier.
module matmul_loader #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [$clog2(DIM):0]                  cfg_m,
  input  logic [$clog2(DIM):0]                  cfg_n,
  input  logic [$clog2(DIM):0]                  cfg_p,
  output logic                                  cfg_err,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BITS-1:0]                       in_data,
  output logic [$clog2(DIM):0]                  m,
  output logic [$clog2(DIM):0]                  n,
  output logic [$clog2(DIM):0]                  p,
  output logic [DIM-1:0][DIM-1:0][BITS-1:0]     matrixDataA,
  output logic [DIM-1:0][DIM-1:0][BITS-1:0]     matrixDataB,
  output logic                                  mm_en,
  input  logic                                  mm_done,
  output logic                                  busy,
  output logic                                  ld_done
);

  localparam int CW = $clog2(DIM) + 1;
  localparam int AW = $clog2(DIM);
  localparam logic [CW-1:0] DIM_W = CW'(DIM);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, RUN} state_e;

  state_e r_state;
  state_e w_next;

  logic [CW-1:0]                    r_m, r_n, r_p;
  logic [CW-1:0]                    r_row, r_col;
  logic [DIM-1:0][DIM-1:0][BITS-1:0] r_a, r_b;
  logic                             r_cfg_err, r_ld_done;

  logic          w_cfg_ok, w_cfg_fire, w_xfer;
  logic [CW-1:0] w_rows, w_cols;
  logic          w_row_last, w_col_last, w_last;
  logic [AW-1:0] w_row_idx, w_col_idx;

  assign w_cfg_ok = (cfg_m != '0) && (cfg_m <= DIM_W) &&
                    (cfg_n != '0) && (cfg_n <= DIM_W) &&
                    (cfg_p != '0) && (cfg_p <= DIM_W);
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_xfer     = in_valid && in_ready;

  // A is m x n, B is n x p; the counter bounds follow whichever operand is loading.
  assign w_rows     = (r_state == LOAD_B) ? r_n : r_m;
  assign w_cols     = (r_state == LOAD_B) ? r_p : r_n;
  assign w_row_last = (r_row == w_rows - ONE);
  assign w_col_last = (r_col == w_cols - ONE);
  assign w_last     = w_row_last && w_col_last;
  assign w_row_idx  = r_row[AW-1:0];
  assign w_col_idx  = r_col[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    mm_en     = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        cfg_ready = !rst;
        if (w_cfg_fire && w_cfg_ok) w_next = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (w_xfer && w_last) w_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (w_xfer && w_last) w_next = RUN;
      end
      RUN: begin
        mm_en = 1'b1;
        if (mm_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the operand arrays are reset because a reset must leave them cleared;
  // state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_n       <= '0;
      r_p       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cfg_err <= 1'b0;
      r_ld_done <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      r_ld_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cfg_fire) begin
            if (w_cfg_ok) begin
              r_m   <= cfg_m;
              r_n   <= cfg_n;
              r_p   <= cfg_p;
              r_a   <= '0;
              r_b   <= '0;
              r_row <= '0;
              r_col <= '0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (w_xfer) begin
            if (r_state == LOAD_A) r_a[w_row_idx][w_col_idx] <= in_data;
            else                   r_b[w_row_idx][w_col_idx] <= in_data;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= w_row_last ? '0 : r_row + ONE;
            end else begin
              r_col <= r_col + ONE;
            end
          end
        end
        RUN: begin
          if (mm_done) r_ld_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m           = r_m;
  assign n           = r_n;
  assign p           = r_p;
  assign matrixDataA = r_a;
  assign matrixDataB = r_b;
  assign cfg_err     = r_cfg_err;
  assign ld_done     = r_ld_done;

endmodule

// File: tb/tb_matmul_loader.sv
// Scoreboard bench for matmul_loader: stimulus pushes expected events, a negedge
// monitor pops and compares them when the DUT raises mm_en, cfg_err or ld_done.
module tb_matmul_loader;

  localparam int BITS = 8;
  localparam int DIM  = 32;
  localparam int CW   = $clog2(DIM) + 1;

  typedef logic [DIM-1:0][DIM-1:0][BITS-1:0] arr_t;
  typedef enum {EV_LOAD, EV_ERR, EV_DONE} ev_e;
  typedef struct {
    ev_e           kind;
    logic [CW-1:0] m, n, p;
    arr_t          a, b;
    int            xfers;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CW-1:0]   cfg_m = '0, cfg_n = '0, cfg_p = '0;
  logic            cfg_err;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_data = '0;
  logic [CW-1:0]   m, n, p;
  arr_t            matrixDataA, matrixDataB;
  logic            mm_en;
  logic            mm_done = 1'b0;
  logic            busy;
  logic            ld_done;

  matmul_loader #(.BITS(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m(m), .n(n), .p(p),
    .matrixDataA(matrixDataA), .matrixDataB(matrixDataB),
    .mm_en(mm_en), .mm_done(mm_done), .busy(busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  int   cur_m = 0, cur_n = 0, cur_p = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_arr(input string name, input arr_t act, input arr_t want);
    int  fr = 0, fc = 0;
    bit  found = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (!found && act[r][c] !== want[r][c]) begin
          fr = r; fc = c; found = 1;
        end
    check($sformatf("%s[%0d][%0d]", name, fr, fc), 32'(act[fr][fc]), 32'(want[fr][fc]));
  endtask

  // Monitor: all DUT observation happens on the falling edge.
  int   cyc = 0, xfers = 0, last_xfer = -10;
  logic prev_mm_en = 1'b0;
  exp_t mon_e;

  task automatic pop_expect(input ev_e kind, output bit ok);
    ok = 0;
    if (sb_q.size() == 0) begin
      check($sformatf("unexpected_event_%s", kind.name()), 1, 0);
    end else begin
      mon_e = sb_q.pop_front();
      check("event_kind", 32'(kind), 32'(mon_e.kind));
      ok = (kind == mon_e.kind);
    end
  endtask

  always @(negedge clk) begin
    bit ok;
    cyc++;
    if (rst) begin
      prev_mm_en = 1'b0;
    end else begin
      if (mm_en && !prev_mm_en) begin
        pop_expect(EV_LOAD, ok);
        if (ok) begin
          check("load_m", 32'(m), 32'(mon_e.m));
          check("load_n", 32'(n), 32'(mon_e.n));
          check("load_p", 32'(p), 32'(mon_e.p));
          check_arr("load_A", matrixDataA, mon_e.a);
          check_arr("load_B", matrixDataB, mon_e.b);
          check("load_xfers", 32'(xfers), 32'(mon_e.xfers));
          check("mm_en_latency", 32'(last_xfer), 32'(cyc - 1));
        end
      end
      if (cfg_err) begin
        pop_expect(EV_ERR, ok);
        if (ok) begin
          check("err_m_kept", 32'(m), 32'(mon_e.m));
          check("err_n_kept", 32'(n), 32'(mon_e.n));
          check("err_p_kept", 32'(p), 32'(mon_e.p));
          check("err_busy", 32'(busy), 0);
        end
      end
      if (ld_done) begin
        pop_expect(EV_DONE, ok);
        if (ok) begin
          check("done_busy", 32'(busy), 0);
          check("done_mm_en", 32'(mm_en), 0);
          check("done_cfg_ready", 32'(cfg_ready), 1);
        end
      end
      if (in_valid && in_ready) begin
        xfers++;
        last_xfer = cyc;
      end
      if (cfg_valid && cfg_ready) xfers = 0;
      prev_mm_en = mm_en;
    end
  end

  // All stimulus tasks start and end 1ns after a rising edge.
  task automatic do_cfg(input int cm, input int cn, input int cp, input bit ok);
    int   g = 0;
    exp_t e;
    while (!cfg_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 1);
    cfg_m = CW'(cm); cfg_n = CW'(cn); cfg_p = CW'(cp);
    cfg_valid = 1'b1;
    if (!ok) begin
      e.kind = EV_ERR; e.m = CW'(cur_m); e.n = CW'(cur_n); e.p = CW'(cur_p);
      e.a = '0; e.b = '0; e.xfers = 0;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (ok) begin
      cur_m = cm; cur_n = cn; cur_p = cp;
      check("in_ready_after_cfg", 32'(in_ready), 1);
    end else begin
      check("in_ready_after_err", 32'(in_ready), 0);
    end
  endtask

  task automatic send(input logic [BITS-1:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Streams base+k (mod 256) for element k; pushes the expected arrays when the
  // whole job is streamed (n_send < 0 means send everything).
  task automatic stream(input int base, input bit gaps, input int n_send);
    int   tot = cur_m * cur_n + cur_n * cur_p;
    int   cnt = (n_send < 0) ? tot : n_send;
    exp_t e;
    if (cnt == tot) begin
      e.kind = EV_LOAD; e.m = CW'(cur_m); e.n = CW'(cur_n); e.p = CW'(cur_p);
      e.a = '0; e.b = '0; e.xfers = tot;
      for (int r = 0; r < cur_m; r++)
        for (int c = 0; c < cur_n; c++)
          e.a[r][c] = BITS'(base + r * cur_n + c);
      for (int r = 0; r < cur_n; r++)
        for (int c = 0; c < cur_p; c++)
          e.b[r][c] = BITS'(base + cur_m * cur_n + r * cur_p + c);
      sb_q.push_back(e);
    end
    for (int k = 0; k < cnt; k++) begin
      send(BITS'(base + k));
      if (gaps) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic finish_job(input int delay);
    exp_t e;
    repeat (delay - 1) begin
      @(posedge clk); #1;
    end
    check("mm_en_before_done", 32'(mm_en), 1);
    e.kind = EV_DONE; e.m = '0; e.n = '0; e.p = '0; e.a = '0; e.b = '0; e.xfers = 0;
    sb_q.push_back(e);
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
    check("ld_done_pulse", 32'(ld_done), 1);
    check("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mm_en", 32'(mm_en), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_cfg_ready", 32'(cfg_ready), 1);
    @(posedge clk); #1;

    // mm_done outside RUN must not produce ld_done
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
    @(posedge clk); #1;
    check("idle_mm_done_ignored", 32'(ld_done), 0);

    // Basic 2x2x2, stream 1..8
    do_cfg(2, 2, 2, 1);
    stream(1, 0, -1);
    check("basic_mm_en", 32'(mm_en), 1);
    check("basic_in_ready", 32'(in_ready), 0);
    check("basic_A10", 32'(matrixDataA[1][0]), 3);
    check("basic_B11", 32'(matrixDataB[1][1]), 8);
    check("basic_A02_zero", 32'(matrixDataA[0][2]), 0);
    finish_job(4);

    // Invalid configs keep prior dims
    do_cfg(0, 2, 2, 0);
    do_cfg(2, 2, DIM + 1, 0);
    @(posedge clk); #1;
    check("err_m_still_2", 32'(m), 2);

    // Non-square 3x2x4 with bubbles, values 1..14
    do_cfg(3, 2, 4, 1);
    stream(1, 1, -1);
    check("ns_in_ready_low", 32'(in_ready), 0);
    check("ns_A21", 32'(matrixDataA[2][1]), 6);
    check("ns_B13", 32'(matrixDataB[1][3]), 14);
    finish_job(2);

    // Max size, value = index mod 256
    do_cfg(DIM, DIM, DIM, 1);
    stream(0, 0, -1);
    check("max_B_last", 32'(matrixDataB[DIM-1][DIM-1]), 255);
    finish_job(1);

    // Reset mid-LOAD_B after 3 B elements
    do_cfg(2, 2, 2, 1);
    stream(50, 0, 7);
    rst = 1'b1;
    #2;
    check("abort_mm_en", 32'(mm_en), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_cfg_ready", 32'(cfg_ready), 0);
    check("abort_m", 32'(m), 0);
    check("abort_A_clear", 32'(|matrixDataA), 0);
    check("abort_B_clear", 32'(|matrixDataB), 0);
    sb_q.delete();
    cur_m = 0; cur_n = 0; cur_p = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh job after abort, then back-to-back 1x1x1 in the ld_done cycle
    do_cfg(2, 2, 2, 1);
    stream(9, 0, -1);
    finish_job(3);
    do_cfg(1, 1, 1, 1);
    stream(8'hAB, 0, -1);
    check("b2b_A00", 32'(matrixDataA[0][0]), 32'h AB);
    check("b2b_B00", 32'(matrixDataB[0][0]), 32'h AC);
    check("b2b_A01_zero", 32'(matrixDataA[0][1]), 0);
    finish_job(2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_loader.md
# matmul_loader

Front-end stage for the systolic matrix multiplier. It accepts a dimension configuration (m, n, p) and a byte stream over a valid/ready handshake. It unpacks the stream row-major into the A (m×n) and B (n×p) operand register arrays, then drives the multiplier's enable until the multiplier reports completion. It owns the operand storage and sequencing; the multiplier only consumes the arrays and dimensions.

## Interface
- BITS, 8, width of one matrix element
- DIM, 32, maximum dimension of any operand matrix
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  loader idle, configuration accepted when cfg_valid&&cfg_ready
- cfg_m, cfg_n, cfg_p  in  $clog2(DIM)+1 each  requested dimensions
- cfg_err  out  1  one-cycle pulse: offered config rejected
- in_valid  in  1  stream element offered
- in_ready  out  1  loader accepting stream elements
- in_data  in  BITS  stream element (all of A row-major, then all of B row-major)
- m, n, p  out  $clog2(DIM)+1 each  latched dimensions to multiplier
- matrixDataA  out  [BITS-1:0] [DIM-1:0][DIM-1:0]  operand A, [row][col]
- matrixDataB  out  [BITS-1:0] [DIM-1:0][DIM-1:0]  operand B, [row][col]
- mm_en  out  1  enable to multiplier
- mm_done  in  1  multiplier completion
- busy  out  1  state != IDLE
- ld_done  out  1  one-cycle pulse, job finished

## Operation
- States: IDLE, LOAD_A, LOAD_B, RUN.
- IDLE: cfg_ready=1, in_ready=0, mm_en=0.
  - On cfg_valid with all dims in 1..DIM: latch m,n,p; zero both arrays; clear row/col counters; go to LOAD_A.
  - Any dim 0 or >DIM: pulse cfg_err next cycle, stay IDLE, keep prior m,n,p and arrays.
- LOAD_A: in_ready=1. Each transfer (in_valid&&in_ready) writes matrixDataA[row][col]=in_data, then advances col. When col==n-1: col=0, row++. Transfer at row==m-1, col==n-1 clears counters and goes to LOAD_B.
- LOAD_B: same, writing matrixDataB, bounds n rows × p cols. The last transfer goes to RUN.
- RUN: in_ready=0, mm_en=1. When mm_done=1: go to IDLE, mm_en=0, pulse ld_done.
- Entries outside the m×n / n×p region stay 0 for the whole job.
- in_valid is ignored in IDLE and RUN. cfg_valid is ignored while busy (cfg_ready=0).
- Arrays and m,n,p hold their values after the job until the next accepted config, so results stay reproducible.

## Timing
- Reset value of every output is 0: cfg_ready=0 during reset, then 1 from the first cycle after release. Reset returns the block to IDLE with the arrays cleared.
- rst asserted mid-job: the job is aborted immediately and asynchronously; mm_en drops with no ld_done.
- Config accepted at edge t: in_ready=1 from t+1.
- One element per cycle at full rate, so the loader needs m·n + n·p transfer cycles.
- Last B transfer at edge k: in_ready=0 and mm_en=1 from k+1.
- mm_done sampled high at edge d: mm_en=0, busy=0, ld_done=1 during cycle d+1; cfg_ready=1 the same cycle.
- mm_done high in any state other than RUN is ignored.
- in_valid deasserting mid-load inserts bubbles; counters hold with no loss or duplication.
- cfg_err lasts one cycle; a new cfg_valid in that cycle is evaluated normally.
- Counter widths are $clog2(DIM)+1 bits. No wrap occurs because bounds are checked against the latched dims.

## Test plan
- Basic load, m=n=p=2, stream 1,2,3,4,5,6,7,8 at full rate: A=[[1,2],[3,4]], B=[[5,6],[7,8]], other entries 0; mm_en rises the cycle after the 8th transfer; hold mm_done=1 one cycle 4 cycles later -> ld_done pulse, busy=0.
- Non-square, m=3, n=2, p=4: 6+8 elements with in_valid toggled every other cycle. A and B are placed correctly; total accepted transfers = 14; in_ready=0 after the 14th.
- Invalid configs cfg_m=0, then cfg_p=DIM+1: each gives a cfg_err pulse, busy stays 0, prior m,n,p are unchanged.
- Max size, m=n=p=DIM, stream value = index mod 256: matrixDataB[DIM-1][DIM-1] = (2·DIM²-1) mod 256; mm_en rises after exactly 2·DIM² transfers.
- Reset mid-LOAD_B after 3 elements (m=n=p=2): all outputs 0 and arrays cleared. A new config then completes normally with no stale data.
- Back-to-back jobs: a second config offered the cycle ld_done pulses is accepted. Arrays are re-zeroed, and smaller dims (1,1,1) leave only [0][0] nonzero.
